// File: rtl/ebox_mbox_req.sv
// ebox_mbox_req
//   EBOX-side memory request arbiter and sequencer. Grants one of NCH
//   requesters round-robin, latches its write flag/address/data, drives the
//   MBOX request until T0, then waits for the response. An MBOX retry
//   re-issues the same request up to MAXRETRY times. A response timeout of
//   TMO cycles ends the transaction with an error. One transaction at a time.
//
// Ports
//   clk, CROBAR           clock, synchronous active-high reset
//   reqValid/Write/Adr/Data  per-channel requests (channel i at [i*W +: W])
//   reqReady              one-hot grant, combinational, in the accepting IDLE cycle
//   mboxReq/Write/Adr/Data   request to MBOX with latched fields
//   mboxT0/Retry/Resp/RdData MBOX accept, retry demand, response strobe, read data
//   respValid/Data/Err    one-cycle completion to the owning channel
//   busy                  state is not IDLE
//   tmoErr, errClr        sticky timeout flag and its clear (set wins)
module ebox_mbox_req #(
    parameter int NCH      = 3,
    parameter int AW       = 23,
    parameter int DW       = 36,
    parameter int MAXRETRY = 7,
    parameter int TMO      = 63
) (
    input  logic                clk,
    input  logic                CROBAR,
    input  logic [NCH-1:0]      reqValid,
    input  logic [NCH-1:0]      reqWrite,
    input  logic [NCH*AW-1:0]   reqAdr,
    input  logic [NCH*DW-1:0]   reqData,
    output logic [NCH-1:0]      reqReady,
    output logic                mboxReq,
    output logic                mboxWrite,
    output logic [AW-1:0]       mboxAdr,
    output logic [DW-1:0]       mboxData,
    input  logic                mboxT0,
    input  logic                mboxRetry,
    input  logic                mboxResp,
    input  logic [DW-1:0]       mboxRdData,
    output logic [NCH-1:0]      respValid,
    output logic [DW-1:0]      respData,
    output logic                respErr,
    output logic                busy,
    output logic                tmoErr,
    input  logic                errClr
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int RW = (MAXRETRY > 0) ? $clog2(MAXRETRY + 1) : 1;
    localparam int TW = $clog2(TMO);

    localparam logic [PW:0]   NCH_V = (PW+1)'(NCH);
    localparam logic [PW-1:0] LAST  = PW'(NCH - 1);
    localparam logic [RW-1:0] RMAX  = RW'(MAXRETRY);
    localparam logic [TW-1:0] TLAST = TW'(TMO - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [RW-1:0]   retry_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            wr;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   data;
    logic [DW-1:0]   resp_data;
    logic            resp_err;
    logic            tmo_err;

    // Round-robin pick: rotate the valid vector so ptr lands at bit 0, take
    // the lowest set bit, then rotate the offset back into channel space.
    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    logic [PW:0]      off;
    logic [PW:0]      sum;
    logic [PW-1:0]    gnt_idx;
    logic             any_req;

    always_comb begin
        dbl = {reqValid, reqValid} >> ptr;
        rot = dbl[NCH-1:0];
        off = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (rot[j]) off = j[PW:0];
        end
        sum = {1'b0, ptr} + off;
        if (sum >= NCH_V) sum = sum - NCH_V;
        gnt_idx = sum[PW-1:0];
        any_req = |reqValid;
    end

    // Timeout fires in the TMO-th REQ/WAIT cycle after the last REQ entry.
    logic tmo_hit;
    assign tmo_hit = ((state == S_REQ) || (state == S_WAIT)) && (tmo_cnt == TLAST);

    always_comb begin
        reqReady = '0;
        if ((state == S_IDLE) && any_req && !CROBAR) reqReady[gnt_idx] = 1'b1;
    end

    always_comb begin
        respValid = '0;
        if (state == S_DONE) respValid[owner] = 1'b1;
    end

    assign mboxReq   = (state == S_REQ);
    assign busy      = (state != S_IDLE);
    assign mboxWrite = wr;
    assign mboxAdr   = adr;
    assign mboxData  = data;
    assign respData  = resp_data;
    assign respErr   = resp_err;
    assign tmoErr    = tmo_err;

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            wr        <= 1'b0;
            adr       <= '0;
            data      <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            tmo_err   <= 1'b0;
        end else begin
            // Clear first so a timeout in the same cycle overrides it.
            if (errClr) tmo_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner     <= gnt_idx;
                        ptr       <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                        wr        <= reqWrite[gnt_idx];
                        adr       <= reqAdr[gnt_idx*AW +: AW];
                        data      <= reqData[gnt_idx*DW +: DW];
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (tmo_hit) begin
                        tmo_err   <= 1'b1;
                        resp_err  <= 1'b1;
                        resp_data <= '0;
                        state     <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (mboxT0) state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tmo_hit) begin
                        tmo_err   <= 1'b1;
                        resp_err  <= 1'b1;
                        resp_data <= '0;
                        state     <= S_DONE;
                    end else if (mboxResp) begin
                        resp_data <= wr ? '0 : mboxRdData;
                        resp_err  <= 1'b0;
                        state     <= S_DONE;
                    end else if (mboxRetry) begin
                        if (retry_cnt < RMAX) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            tmo_cnt   <= '0;
                            state     <= S_REQ;
                        end else begin
                            resp_err  <= 1'b1;
                            resp_data <= '0;
                            state     <= S_DONE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    resp_err  <= 1'b0;
                    resp_data <= '0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ebox_mbox_req.sv
// tb_ebox_mbox_req
//   Directed scenarios with literal expectations, then randomized traffic.
//   A transaction-level reference model tracks ownership, bus issue,
//   age since issue and retries, and is compared against the DUT each cycle.
module tb_ebox_mbox_req;

    localparam int NCH = 3, AW = 23, DW = 36, MAXRETRY = 7, TMO = 63;

    logic              clk = 1'b0;
    logic              CROBAR = 1'b1;
    logic [NCH-1:0]    reqValid = '0;
    logic [NCH-1:0]    reqWrite = '0;
    logic [NCH*AW-1:0] reqAdr = '0;
    logic [NCH*DW-1:0] reqData = '0;
    logic [NCH-1:0]    reqReady;
    logic              mboxReq, mboxWrite;
    logic [AW-1:0]     mboxAdr;
    logic [DW-1:0]     mboxData;
    logic              mboxT0 = 1'b0, mboxRetry = 1'b0, mboxResp = 1'b0;
    logic [DW-1:0]     mboxRdData = '0;
    logic [NCH-1:0]    respValid;
    logic [DW-1:0]     respData;
    logic              respErr, busy, tmoErr;
    logic              errClr = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    ebox_mbox_req #(.NCH(NCH), .AW(AW), .DW(DW), .MAXRETRY(MAXRETRY), .TMO(TMO)) dut (
        .clk(clk), .CROBAR(CROBAR),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqAdr(reqAdr), .reqData(reqData),
        .reqReady(reqReady),
        .mboxReq(mboxReq), .mboxWrite(mboxWrite), .mboxAdr(mboxAdr), .mboxData(mboxData),
        .mboxT0(mboxT0), .mboxRetry(mboxRetry), .mboxResp(mboxResp), .mboxRdData(mboxRdData),
        .respValid(respValid), .respData(respData), .respErr(respErr),
        .busy(busy), .tmoErr(tmoErr), .errClr(errClr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    bit             mdl_on = 0;
    int             m_owner = -1, m_ptr = 0, m_age = 0, m_tries = 0;
    bit             m_onbus = 0, m_done = 0, m_tmo = 0, m_rerr = 0, m_wr = 0;
    logic [AW-1:0]  m_adr = '0;
    logic [DW-1:0]  m_data = '0, m_rdata = '0;

    always @(negedge clk) begin
        logic [NCH-1:0] e_rdy, e_rv;
        int g;
        g = -1;
        if (m_owner < 0 && !CROBAR)
            for (int k = 0; k < NCH; k++)
                if (g < 0 && reqValid[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        e_rv = '0;
        if (m_done) e_rv[m_owner] = 1'b1;

        if (mdl_on) begin
            chk("m_reqReady", 64'(reqReady), 64'(e_rdy));
            chk("m_respValid", 64'(respValid), 64'(e_rv));
            chk("m_busy", 64'(busy), 64'(m_owner >= 0));
            chk("m_mboxReq", 64'(mboxReq), 64'(m_onbus));
            chk("m_tmoErr", 64'(tmoErr), 64'(m_tmo));
            chk("m_mboxWrite", 64'(mboxWrite), 64'(m_wr));
            chk("m_mboxAdr", 64'(mboxAdr), 64'(m_adr));
            chk("m_mboxData", 64'(mboxData), 64'(m_data));
            if (m_done) begin
                chk("m_respErr", 64'(respErr), 64'(m_rerr));
                chk("m_respData", 64'(respData), 64'(m_rdata));
            end
        end

        if (CROBAR) begin
            mdl_on = 1; m_owner = -1; m_ptr = 0; m_age = 0; m_tries = 0;
            m_onbus = 0; m_done = 0; m_tmo = 0; m_wr = 0; m_adr = '0; m_data = '0;
        end else if (mdl_on) begin
            if (errClr) m_tmo = 0;
            if (g >= 0) begin
                m_owner = g; m_ptr = (g + 1) % NCH;
                m_wr = reqWrite[g]; m_adr = reqAdr[g*AW +: AW]; m_data = reqData[g*DW +: DW];
                m_onbus = 1; m_age = 0; m_tries = 0;
            end else if (m_done) begin
                m_done = 0; m_owner = -1;
            end else if (m_owner >= 0) begin
                m_age++;
                if (m_age == TMO) begin
                    m_tmo = 1; m_done = 1; m_onbus = 0; m_rerr = 1; m_rdata = '0;
                end else if (m_onbus) begin
                    if (mboxT0) m_onbus = 0;
                end else if (mboxResp) begin
                    m_done = 1; m_rerr = 0; m_rdata = m_wr ? '0 : mboxRdData;
                end else if (mboxRetry) begin
                    if (m_tries < MAXRETRY) begin
                        m_tries++; m_onbus = 1; m_age = 0;
                    end else begin
                        m_done = 1; m_rerr = 1; m_rdata = '0;
                    end
                end
            end
        end
    end

    // ---------------- directed transaction driver ----------------
    task automatic serve(input logic [NCH-1:0] vld, input int nretry, input bit give_t0,
                         input bit both, input logic [DW-1:0] rd,
                         output int gch, output int issues, output bit err,
                         output logic [DW-1:0] data, output int lat);
        int left, gcyc;
        bit prev, fin;
        left = nretry; prev = 0; fin = 0; gch = -1; issues = 0;
        err = 0; data = '0; lat = -1; gcyc = 0;
        for (int c = 0; c < 300 && !fin; c++) begin
            cyc();
            reqValid = vld; mboxT0 = 0; mboxResp = 0; mboxRetry = 0;
            if (mboxReq) begin
                if (!prev) issues++;
                mboxT0 = give_t0;
            end else if (busy && respValid == '0) begin
                if (left > 0) begin
                    mboxRetry = 1; left--;
                end else begin
                    mboxResp = 1; mboxRdData = rd; mboxRetry = both;
                end
            end
            prev = mboxReq;
            smp();
            if (reqReady != '0 && gch < 0) begin
                for (int j = 0; j < NCH; j++) if (reqReady[j]) gch = j;
                gcyc = c;
            end
            if (respValid != '0) begin
                fin = 1; err = respErr; data = respData; lat = c - gcyc;
            end
        end
        if (!fin) chk("serve_completion", 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        cyc(); CROBAR = 1; reqValid = '0; mboxT0 = 0; mboxResp = 0; mboxRetry = 0; errClr = 0;
        cyc(); CROBAR = 0;
    endtask

    // ---------------- stimulus ----------------
    logic [NCH-1:0] pend, last_gnt;

    initial begin
        int g, iss, lat;
        bit e;
        logic [DW-1:0] d;

        cyc(); cyc();
        smp();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_mboxReq", 64'(mboxReq), 64'(0));
        chk("rst_respValid", 64'(respValid), 64'(0));
        chk("rst_tmoErr", 64'(tmoErr), 64'(0));
        chk("rst_mboxAdr", 64'(mboxAdr), 64'(0));
        cyc(); CROBAR = 0;

        // single read on ch0
        reqAdr[0 +: AW] = 23'o1234; reqWrite = '0;
        serve(3'b001, 0, 1, 0, 36'o777777000001, g, iss, e, d, lat);
        chk("rd_grant", 64'(g), 64'(0));
        chk("rd_data", 64'(d), 64'(36'o777777000001));
        chk("rd_err", 64'(e), 64'(0));
        chk("rd_latency", 64'(lat), 64'(3));
        chk("rd_adr", 64'(mboxAdr), 64'(23'o1234));

        // round robin
        do_reset();
        reqAdr[AW +: AW] = 23'o2000; reqAdr[2*AW +: AW] = 23'o3000;
        for (int t = 0; t < 3; t++) begin
            serve(3'b111, 0, 1, 0, 36'h5, g, iss, e, d, lat);
            chk("rr_grant", 64'(g), 64'(t));
        end
        serve(3'b001, 0, 1, 0, 36'h5, g, iss, e, d, lat);
        chk("rr_only0", 64'(g), 64'(0));

        // three retries then response
        serve(3'b010, 3, 1, 0, 36'h123, g, iss, e, d, lat);
        chk("retry3_issues", 64'(iss), 64'(4));
        chk("retry3_err", 64'(e), 64'(0));
        chk("retry3_data", 64'(d), 64'(36'h123));

        // retry exhausted
        serve(3'b100, MAXRETRY + 1, 1, 0, 36'h99, g, iss, e, d, lat);
        chk("retryx_issues", 64'(iss), 64'(MAXRETRY + 1));
        chk("retryx_err", 64'(e), 64'(1));
        chk("retryx_data", 64'(d), 64'(0));
        cyc(); reqValid = '0; mboxRetry = 0; mboxResp = 0;
        smp();
        chk("retryx_noreissue", 64'(mboxReq), 64'(0));
        chk("retryx_idle", 64'(busy), 64'(0));

        // simultaneous response and retry
        serve(3'b001, 0, 1, 1, 36'hABC, g, iss, e, d, lat);
        chk("both_issues", 64'(iss), 64'(1));
        chk("both_err", 64'(e), 64'(0));
        chk("both_data", 64'(d), 64'(36'hABC));

        // timeout
        serve(3'b001, 0, 0, 0, 36'h0, g, iss, e, d, lat);
        chk("tmo_latency", 64'(lat), 64'(TMO + 1));
        chk("tmo_err", 64'(e), 64'(1));
        chk("tmo_flag", 64'(tmoErr), 64'(1));
        chk("tmo_issues", 64'(iss), 64'(1));
        cyc(); reqValid = '0; errClr = 1;
        cyc(); errClr = 0;
        smp();
        chk("tmo_clr", 64'(tmoErr), 64'(0));

        // reset during WAIT
        cyc(); reqValid = 3'b001; reqData[0 +: DW] = 36'h77;
        smp();
        cyc(); reqValid = '0; mboxT0 = 1;
        cyc(); mboxT0 = 0; CROBAR = 1;
        smp();
        chk("crb_in_wait", 64'(busy && !mboxReq), 64'(1));
        cyc(); CROBAR = 0;
        smp();
        chk("crb_busy", 64'(busy), 64'(0));
        chk("crb_mboxReq", 64'(mboxReq), 64'(0));
        chk("crb_mboxAdr", 64'(mboxAdr), 64'(0));
        chk("crb_mboxData", 64'(mboxData), 64'(0));
        chk("crb_respValid", 64'(respValid), 64'(0));
        cyc(); smp();
        chk("crb_nopulse", 64'(respValid), 64'(0));
        serve(3'b010, 0, 1, 0, 36'h4321, g, iss, e, d, lat);
        chk("crb_next_grant", 64'(g), 64'(1));
        chk("crb_next_data", 64'(d), 64'(36'h4321));
        chk("crb_next_err", 64'(e), 64'(0));

        // randomized traffic
        pend = '0; last_gnt = '0;
        for (int c = 0; c < 3000; c++) begin
            int ph;
            cyc();
            ph = c % 512;
            pend = pend & ~last_gnt;
            for (int i = 0; i < NCH; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i] = 1;
                    reqWrite[i] = $urandom_range(1) == 1;
                    reqAdr[i*AW +: AW] = AW'($urandom);
                    reqData[i*DW +: DW] = DW'({$urandom, $urandom});
                end
            end
            reqValid = pend;
            mboxT0 = $urandom_range(2) == 0;
            mboxResp = $urandom_range(3) == 0;
            mboxRetry = $urandom_range(4) == 0;
            mboxRdData = DW'({$urandom, $urandom});
            errClr = $urandom_range(15) == 0;
            CROBAR = $urandom_range(499) == 0;
            if (ph >= 200 && ph < 300) begin
                mboxResp = 0;
                mboxRetry = $urandom_range(1) == 1;
                mboxT0 = $urandom_range(1) == 1;
            end
            if (ph >= 400 && ph < 480) begin
                mboxT0 = 0; mboxResp = 0; mboxRetry = 0;
            end
            smp();
            last_gnt = reqReady;
        end

        cyc();
        CROBAR = 0; reqValid = '0; mboxT0 = 0; mboxResp = 0; mboxRetry = 0; errClr = 0;
        cyc(); cyc();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
